// File: rtl/pg_pkg.sv
// Shared types for the RAM power-gating sequencer and its refill generator.
// Refill pattern selectors; the global header normally provides these first.
`ifndef RAM_RESET_ZERO
`define RAM_RESET_ZERO 1
`endif
`ifndef RAM_RESET_SEQ
`define RAM_RESET_SEQ 2
`endif

package pg_pkg;

  typedef enum logic [2:0] {
    PG_ON    = 3'd0,
    PG_DRAIN = 3'd1,
    PG_GATED = 3'd2,
    PG_WAKE  = 3'd3,
    PG_FILL  = 3'd4
  } pgState_t;

  localparam int RESET_ZERO = `RAM_RESET_ZERO;
  localparam int RESET_SEQ  = `RAM_RESET_SEQ;

  // Any selector other than ZERO or SEQ leaves the woken RAM unfilled.
  function automatic logic refill_en(input int mode);
    return (mode == RESET_ZERO) || (mode == RESET_SEQ);
  endfunction

endpackage

// File: rtl/ram_pg_fill.sv
// Refill address counter and reset-pattern generator used after a RAM wakes up.
// Walks addresses 0..DEPTH-1, one per step, and flags the last entry.
module ram_pg_fill
  import pg_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int INDEX     = 6,
  parameter int WIDTH     = 32,
  parameter int RESET_VAL = `RAM_RESET_ZERO,
  parameter int SEQ_START = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  output logic [INDEX-1:0] addr_o,
  output logic [WIDTH-1:0] data_o,
  output logic             done_o
);

  localparam logic [INDEX-1:0] LAST_ADDR = INDEX'(DEPTH - 1);
  localparam logic [WIDTH-1:0] SEQ_BASE  = WIDTH'(SEQ_START);

  logic [INDEX-1:0] cnt_q, cnt_d;

  assign addr_o = cnt_q;
  assign done_o = step && (cnt_q == LAST_ADDR);

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = done_o ? '0 : cnt_q + 1'b1;
    end
  end

  // SEQ wraps naturally at WIDTH bits; ZERO and "no refill" both yield zero.
  always_comb begin
    data_o = '0;
    if (RESET_VAL == RESET_SEQ) begin
      data_o = SEQ_BASE + WIDTH'(cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_pg_ctrl.sv
// Power-gating sequencer for one RAM_PG_1R1W: drains writes, gates, and on
// wake waits for supply settling then refills every entry before reopening.
module ram_pg_ctrl
  import pg_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int INDEX       = 6,
  parameter int WIDTH       = 32,
  parameter int RESET_VAL   = `RAM_RESET_ZERO,
  parameter int SEQ_START   = 0,
  parameter int WAKE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwrDown_i,
  input  logic             usrWe_i,
  input  logic [INDEX-1:0] usrAddr_i,
  input  logic [WIDTH-1:0] usrData_i,
  output logic             pwrGate_o,
  output logic             we_o,
  output logic [INDEX-1:0] addrWr_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ready_o,
  output logic             dropWr_o
);

  localparam int                WCNT_W    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_CYCLES - 1);
  localparam logic              DO_FILL   = refill_en(RESET_VAL);

  pgState_t          state_q, state_d;
  logic [WCNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic              pwr_gate_q, pwr_gate_d;
  logic              ready_q, ready_d;

  logic              fill_start;
  logic              fill_step;
  logic              fill_done;
  logic [INDEX-1:0]  fill_addr;
  logic [WIDTH-1:0]  fill_data;

  ram_pg_fill #(
    .DEPTH     (DEPTH),
    .INDEX     (INDEX),
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL),
    .SEQ_START (SEQ_START)
  ) u_fill (
    .clk    (clk),
    .reset  (reset),
    .start  (fill_start),
    .step   (fill_step),
    .addr_o (fill_addr),
    .data_o (fill_data),
    .done_o (fill_done)
  );

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    fill_start = 1'b0;
    fill_step  = 1'b0;
    case (state_q)
      PG_ON: begin
        if (pwrDown_i) state_d = PG_DRAIN;
      end
      PG_DRAIN: begin
        state_d = PG_GATED;
      end
      PG_GATED: begin
        if (!pwrDown_i) begin
          state_d    = PG_WAKE;
          wake_cnt_d = '0;
        end
      end
      PG_WAKE: begin
        // A renewed power-down request aborts the wake before any write is issued.
        if (pwrDown_i) begin
          state_d = PG_GATED;
        end else if (wake_cnt_q == WAKE_LAST) begin
          if (DO_FILL) begin
            state_d    = PG_FILL;
            fill_start = 1'b1;
          end else begin
            state_d = PG_ON;
          end
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      PG_FILL: begin
        fill_step = 1'b1;
        if (fill_done) state_d = PG_ON;
      end
      default: begin
        state_d = PG_ON;
      end
    endcase

    // Gate and ready are registered from the next state so they never glitch.
    pwr_gate_d = (state_d == PG_GATED);
    ready_d    = (state_d == PG_ON);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= PG_ON;
      wake_cnt_q <= '0;
      pwr_gate_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      pwr_gate_q <= pwr_gate_d;
      ready_q    <= ready_d;
    end
  end

  // Only ON passes user writes; everywhere else a user write is reported as dropped.
  always_comb begin
    we_o     = 1'b0;
    addrWr_o = usrAddr_i;
    data_o   = usrData_i;
    dropWr_o = 1'b0;
    case (state_q)
      PG_ON: begin
        we_o = usrWe_i;
      end
      PG_FILL: begin
        we_o     = 1'b1;
        addrWr_o = fill_addr;
        data_o   = fill_data;
        dropWr_o = usrWe_i;
      end
      default: begin
        dropWr_o = usrWe_i;
      end
    endcase
  end

  assign pwrGate_o = pwr_gate_q;
  assign ready_o   = ready_q;

endmodule

// File: tb/tb_ram_pg_ctrl.sv
// Bench for ram_pg_ctrl: per-cycle vector table plus a write scoreboard.
`ifndef RAM_RESET_ZERO
`define RAM_RESET_ZERO 1
`endif
`ifndef RAM_RESET_SEQ
`define RAM_RESET_SEQ 2
`endif

module tb_ram_pg_ctrl;

  localparam int DEPTH     = 8;
  localparam int INDEX     = 3;
  localparam int WIDTH     = 8;
  localparam int WAKE      = 4;
  localparam int SEQ_START = 'h10;

  logic             clk = 1'b0;
  logic             reset;
  logic             pwrDown_i;
  logic             usrWe_i;
  logic [INDEX-1:0] usrAddr_i;
  logic [WIDTH-1:0] usrData_i;
  logic             pwrGate_o;
  logic             we_o;
  logic [INDEX-1:0] addrWr_o;
  logic [WIDTH-1:0] data_o;
  logic             ready_o;
  logic             dropWr_o;

  ram_pg_ctrl #(
    .DEPTH       (DEPTH),
    .INDEX       (INDEX),
    .WIDTH       (WIDTH),
    .RESET_VAL   (`RAM_RESET_SEQ),
    .SEQ_START   (SEQ_START),
    .WAKE_CYCLES (WAKE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pwrDown_i (pwrDown_i),
    .usrWe_i   (usrWe_i),
    .usrAddr_i (usrAddr_i),
    .usrData_i (usrData_i),
    .pwrGate_o (pwrGate_o),
    .we_o      (we_o),
    .addrWr_o  (addrWr_o),
    .data_o    (data_o),
    .ready_o   (ready_o),
    .dropWr_o  (dropWr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pd;
    logic       we;
    logic [2:0] a;
    logic [7:0] d;
    logic       e_rdy;
    logic       e_gate;
    logic       e_we;
    logic       e_drop;
    logic [2:0] e_addr;
    logic [7:0] e_data;
  } vec_t;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  vec_t tbl[$];
  wr_t  sb_q[$];
  wr_t  sb_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic pd, input logic we, input logic [2:0] a,
                              input logic [7:0] d, input logic r, input logic g,
                              input logic w, input logic dr, input logic [2:0] ea,
                              input logic [7:0] ed);
    vec_t v;
    v.pd = pd; v.we = we; v.a = a; v.d = d;
    v.e_rdy = r; v.e_gate = g; v.e_we = w; v.e_drop = dr;
    v.e_addr = ea; v.e_data = ed;
    return v;
  endfunction

  // Drive one cycle's inputs just after the edge, queue the expected write, check levels.
  task automatic apply(input vec_t v, input string tag);
    wr_t w;
    @(posedge clk);
    #1;
    pwrDown_i = v.pd;
    usrWe_i   = v.we;
    usrAddr_i = v.a;
    usrData_i = v.d;
    if (v.e_we) begin
      w.addr = v.e_addr;
      w.data = v.e_data;
      sb_q.push_back(w);
    end
    #1;
    chk({tag, "_ready"}, 32'(ready_o),   32'(v.e_rdy));
    chk({tag, "_gate"},  32'(pwrGate_o), 32'(v.e_gate));
    chk({tag, "_we"},    32'(we_o),      32'(v.e_we));
    chk({tag, "_drop"},  32'(dropWr_o),  32'(v.e_drop));
  endtask

  // Every RAM write is matched against the scoreboard; safety invariants ride along.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("gate_and_ready", 32'(pwrGate_o & ready_o), 32'd0);
      chk("gate_and_we",    32'(pwrGate_o & we_o),    32'd0);
      if (we_o) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_write: got addr %0h data %0h expected no write at %0t",
                   addrWr_o, data_o, $time);
        end else begin
          sb_e = sb_q.pop_front();
          chk("sb_addr", 32'(addrWr_o), 32'(sb_e.addr));
          chk("sb_data", 32'(data_o),   32'(sb_e.data));
        end
      end
    end
  end

  initial begin
    // Cycle numbering starts at the first edge after reset release.
    tbl.push_back(mk(0, 1, 3'd3, 8'hA5, 1, 0, 1, 0, 3'd3, 8'hA5));
    tbl.push_back(mk(0, 0, 3'd0, 8'h00, 1, 0, 0, 0, 3'd0, 8'h00));
    tbl.push_back(mk(1, 1, 3'd5, 8'h5A, 1, 0, 1, 0, 3'd5, 8'h5A));
    tbl.push_back(mk(1, 1, 3'd6, 8'h66, 0, 0, 0, 1, 3'd0, 8'h00));
    tbl.push_back(mk(1, 1, 3'd7, 8'h77, 0, 1, 0, 1, 3'd0, 8'h00));
    tbl.push_back(mk(1, 0, 3'd0, 8'h00, 0, 1, 0, 0, 3'd0, 8'h00));
    tbl.push_back(mk(0, 1, 3'd1, 8'h11, 0, 1, 0, 1, 3'd0, 8'h00));
    tbl.push_back(mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd0, 8'h00));
    tbl.push_back(mk(1, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd0, 8'h00));
    tbl.push_back(mk(1, 0, 3'd0, 8'h00, 0, 1, 0, 0, 3'd0, 8'h00));
    tbl.push_back(mk(0, 0, 3'd0, 8'h00, 0, 1, 0, 0, 3'd0, 8'h00));
    for (int k = 0; k < WAKE; k++)
      tbl.push_back(mk(0, k == 1, 3'd2, 8'hEE, 0, 0, 0, k == 1, 3'd0, 8'h00));
    for (int k = 0; k < DEPTH; k++)
      tbl.push_back(mk(k == 3, k % 2 == 1, 3'(7 - k), 8'hFF, 0, 0, 1, k % 2 == 1,
                       3'(k), 8'(SEQ_START + k)));
    tbl.push_back(mk(0, 1, 3'd2, 8'hC3, 1, 0, 1, 0, 3'd2, 8'hC3));
    tbl.push_back(mk(0, 0, 3'd0, 8'h00, 1, 0, 0, 0, 3'd0, 8'h00));

    reset     = 1'b1;
    pwrDown_i = 1'b0;
    usrWe_i   = 1'b0;
    usrAddr_i = '0;
    usrData_i = '0;
    #2;
    chk("rst_ready", 32'(ready_o),   32'd1);
    chk("rst_gate",  32'(pwrGate_o), 32'd0);
    chk("rst_we",    32'(we_o),      32'd0);
    chk("rst_drop",  32'(dropWr_o),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

    // Second wake, interrupted by an asynchronous reset while filling address 4.
    apply(mk(1, 0, 3'd0, 8'h00, 1, 0, 0, 0, 3'd0, 8'h00), "ar_on");
    apply(mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd0, 8'h00), "ar_drain");
    apply(mk(0, 0, 3'd0, 8'h00, 0, 1, 0, 0, 3'd0, 8'h00), "ar_gated");
    for (int k = 0; k < WAKE; k++)
      apply(mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd0, 8'h00), $sformatf("ar_wake%0d", k));
    for (int k = 0; k < 4; k++)
      apply(mk(0, 0, 3'd0, 8'h00, 0, 0, 1, 0, 3'(k), 8'(SEQ_START + k)),
            $sformatf("ar_fill%0d", k));
    @(posedge clk);
    #1;
    chk("ar_pre_we",   32'(we_o),     32'd1);
    chk("ar_pre_addr", 32'(addrWr_o), 32'd4);
    chk("ar_pre_data", 32'(data_o),   32'(SEQ_START + 4));
    reset = 1'b1;
    #1;
    chk("ar_ready", 32'(ready_o),   32'd1);
    chk("ar_gate",  32'(pwrGate_o), 32'd0);
    chk("ar_we",    32'(we_o),      32'd0);
    chk("ar_drop",  32'(dropWr_o),  32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    apply(mk(0, 1, 3'd4, 8'h77, 1, 0, 1, 0, 3'd4, 8'h77), "post_wr");
    apply(mk(0, 0, 3'd0, 8'h00, 1, 0, 0, 0, 3'd0, 8'h00), "post_idle");
    @(posedge clk);
    #1;
    chk("sb_pending", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_pg_ctrl.md
Name: ram_pg_ctrl

Overview:
Power-gating sequencer that drives the gate, write and readiness side of one RAM_PG_1R1W instance.
- Gating: on a power-down request it quiesces writes, then asserts pwrGate_o.
- Wake-up: on release it waits a settling interval, then rewrites every entry with its reset value, because gated RAM contents come back as X.
- After the rewrite it reopens the RAM to the user write port.
- Placement: one instance per power-gateable lane/partition structure in the scalable backend.

Parameters:
DEPTH, 64, RAM entries.
INDEX, 6, address width (log2 DEPTH).
WIDTH, 32, data width.
RESET_VAL, `RAM_RESET_ZERO, refill pattern: `RAM_RESET_ZERO, `RAM_RESET_SEQ, or any other value meaning no refill.
SEQ_START, 0, first value for the SEQ pattern.
WAKE_CYCLES, 4, settling cycles after ungating (≥1).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
pwrDown_i  in  1  level request: 1 = partition should be gated
usrWe_i  in  1  user write enable
usrAddr_i  in  INDEX  user write address
usrData_i  in  WIDTH  user write data
pwrGate_o  out  1  to RAM pwrGate_i
we_o  out  1  to RAM we_i
addrWr_o  out  INDEX  to RAM addrWr_i
data_o  out  WIDTH  to RAM data_i
ready_o  out  1  RAM readable/writable; read data is valid only while ready_o=1
dropWr_o  out  1  one-cycle pulse: usrWe_i was asserted while ready_o=0 and the write was discarded

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- States: ON, DRAIN, GATED, WAKE, FILL. The state register and wake/fill counters are asynchronously reset.
- Reset values: state=ON, pwrGate_o=0, ready_o=1, we_o=0, dropWr_o=0, counters=0.
  - An async reset mid-sequence returns to ON immediately.
  - RAM contents after that come from the RAM's own synchronous reset; the system holds reset ≥1 clk edge.
- ON: ready_o=1.
  - we_o=usrWe_i, addrWr_o=usrAddr_i, data_o=usrData_i (combinational pass-through).
  - pwrDown_i=1 sampled -> DRAIN.
- DRAIN: one cycle, ready_o=0, we_o=0 -> GATED.
- GATED: pwrGate_o=1 (registered, from state), ready_o=0, we_o=0.
  - pwrDown_i=0 sampled -> WAKE with the wake counter cleared.
- WAKE: pwrGate_o=0, ready_o=0, we_o=0. Counts WAKE_CYCLES cycles.
  - pwrDown_i=1 during WAKE -> GATED next cycle (abort).
  - When the count completes: -> FILL if RESET_VAL is ZERO or SEQ, else -> ON.
- FILL: ready_o=0, we_o=1, addrWr_o=fill counter 0..DEPTH-1, one entry per cycle.
  - data_o: 0 for ZERO; (SEQ_START+addr) truncated to WIDTH for SEQ.
  - After address DEPTH-1 is written -> ON.
  - pwrDown_i is ignored during FILL. It is re-evaluated in ON, so a FILL always completes.
- Latency:
  - Power-down: pwrDown_i rises in ON at cycle t -> ready_o=0 at t+1 -> pwrGate_o=1 at t+2.
  - Wake: pwrDown_i falls in GATED at t -> pwrGate_o=0 at t+1 -> first fill write at t+1+WAKE_CYCLES -> ready_o=1 at t+1+WAKE_CYCLES+DEPTH.
- Write precedence: a user write in the same cycle that ON is left (pwrDown_i=1) is accepted, because ON is still the current state. In every non-ON state, usrWe_i=1 produces dropWr_o=1 that cycle and we_o carries only fill writes.
- pwrGate_o and ready_o are never both 1.
- we_o is never 1 while pwrGate_o=1.

Decomposition:
- Shared package (pg_pkg): pgState_t enum (ON, DRAIN, GATED, WAKE, FILL). The `RAM_RESET_ZERO/`RAM_RESET_SEQ macros stay in the existing global header.
- Sub-module ram_pg_fill: fill address counter plus pattern generator.
  - Inputs: start, RESET_VAL/SEQ_START parameters.
  - Outputs: addr, data, done on the last entry.

Test Plan (DEPTH=8, INDEX=3, WIDTH=8, WAKE_CYCLES=4, paired with RAM_PG_1R1W):
- Reset then user write addr 3 data 0xA5 in ON -> we_o=1, addrWr_o=3, data_o=0xA5 same cycle; RAM reads 0xA5 at addr 3.
- pwrDown_i=1 at cycle 10 -> ready_o=0 at 11, pwrGate_o=1 at 12; RAM reads X.
- Release at cycle 20, RESET_VAL=SEQ, SEQ_START=0x10:
  - pwrGate_o=0 at 21.
  - Fill writes addr 0..7 with 0x10..0x17 in cycles 25..32.
  - ready_o=1 at 33; all entries read back correctly.
- usrWe_i=1 while GATED and during FILL -> dropWr_o pulses each such cycle; no corruption of fill values.
- pwrDown_i re-asserted at 2nd WAKE cycle -> pwrGate_o=1 next cycle, no fill writes issued.
- Async reset asserted mid-FILL (addr 4) -> same instant pwrGate_o=0, ready_o=1, we_o=0; after reset release the RAM reads zero (RESET_VAL=ZERO).
